conf_sched: RTL and testbench
=============================

CONF_SCHED -- requirements
Module: conf_sched

Interface
Parameters:
REQ-001 SHALL have parameter GAP_MIN, default 64: consecutive burst_act-low cycles required before a commit.
REQ-002 SHALL have parameter TMO_CYC, default 65535: maximum cycles spent in ARMED before abort.
REQ-003 SHALL have parameter SHIFT_MAX, default 200: upper clamp for pred_shift writes.

Ports:
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port wr_valid, input, 1 bit: one-cycle write strobe from the UART decoder.
REQ-007 SHALL have port wr_addr, input, 2 bits: shadow register select (0 gen_inp, 1 pred_shift, 2 ocd_pw, 3 int_duty).
REQ-008 SHALL have port wr_data, input, 8 bits: write value.
REQ-009 SHALL have port commit_req, input, 1 bit: strobe requesting shadow-to-active transfer.
REQ-010 SHALL have port burst_act, input, 1 bit: interrupter output, high during a burst.
REQ-011 SHALL have ports gen_inp, output, 8 bits; pred_shift, output, 8 bits; ocd_pw, output, 7 bits; int_duty, output, 8 bits: active parameters driving the datapath.
REQ-012 SHALL have ports busy, output, 1 bit (state != IDLE); commit_done, output, 1 bit (one-cycle pulse); tmo_err, output, 1 bit (sticky).

Function
REQ-013 SHALL write wr_data into the addressed shadow register on every wr_valid cycle, in any state; ocd_pw takes wr_data[6:0]; pred_shift is clamped to SHIFT_MAX.
REQ-014 SHALL keep a gap counter: clear on burst_act high, else increment, saturating at GAP_MIN.
REQ-015 SHALL implement the FSM IDLE -> ARMED -> COMMIT -> IDLE: commit_req in IDLE moves to ARMED on the next edge.
REQ-016 SHALL move from ARMED to COMMIT when the gap counter equals GAP_MIN and burst_act is low in the same cycle.
REQ-017 SHALL, in COMMIT, load all four active registers from shadow at the end of that cycle, assert commit_done in the first cycle the new values appear, and return to IDLE.
REQ-018 SHALL ignore commit_req while in ARMED or COMMIT; the ARMED timer is not restarted.
REQ-019 SHALL include a write coinciding with the COMMIT cycle in that commit; the latest write to an address always wins.
REQ-020 SHALL complete COMMIT even if burst_act rises during the COMMIT cycle.
REQ-021 SHALL, when the gap is already satisfied at commit_req, give a minimum latency of commit_req to new outputs of 3 edges (IDLE->ARMED->COMMIT->load).
REQ-022 SHALL never change active outputs outside COMMIT.

Reset
REQ-023 SHALL, on rst, set FSM=IDLE, gap counter=0, tmo_err=0, commit_done=0, and both shadow and active registers to gen_inp=0, pred_shift=30, ocd_pw=87, int_duty=0.
REQ-024 SHALL, on rst asserted in ARMED or COMMIT, abandon the pending commit; rst takes priority over wr_valid in the same cycle.

Configuration
REQ-025 SHALL, with CONF_SCHED_TMO_EN defined, count cycles in ARMED; on reaching TMO_CYC, return to IDLE without committing, set tmo_err (cleared only by rst), and retain shadow contents.
REQ-026 SHALL, without CONF_SCHED_TMO_EN, wait in ARMED indefinitely and tie tmo_err to 0.

Structure
REQ-027 SHALL place the state enum, register address constants and the four reset defaults in shared package conf_pkg.
REQ-028 SHALL implement the gap counter as sub-module gap_cnt (ports clk, rst, burst_act, gap_ok).

Verification
REQ-029 SHALL cover basic commit: after reset, write addr1=0x50, commit_req with burst_act low ≥64 cycles -> pred_shift=0x50 three edges later, with a one-cycle commit_done.
REQ-030 SHALL cover the burst hold-off: burst_act high at commit_req, drops at cycle 100 -> no output change until gap counter=64, then commit.
REQ-031 SHALL cover clamping: write addr1=0xFF -> pred_shift=200 after commit; write addr2=0xFF -> ocd_pw=0x7F.
REQ-032 SHALL cover the timeout: with CONF_SCHED_TMO_EN and TMO_CYC=1000, burst_act held high -> busy falls and tmo_err rises after 1000 cycles, outputs unchanged.
REQ-033 SHALL cover a write coinciding with COMMIT: write addr3=0x22 in the COMMIT cycle -> int_duty=0x22 committed.
REQ-034 SHALL cover reset mid-ARMED: rst while ARMED -> IDLE, outputs back to 0/30/87/0, no commit_done.

Source files
------------

// File: rtl/conf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : conf_pkg                                                |
// | Purpose  : Shared types and constants for the configuration        |
// |            scheduler: FSM states, register addresses, reset values.|
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package conf_pkg;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Shadow register addresses on wr_addr
    localparam logic [1:0] c_ADDR_GEN_INP    = 2'd0;
    localparam logic [1:0] c_ADDR_PRED_SHIFT = 2'd1;
    localparam logic [1:0] c_ADDR_OCD_PW     = 2'd2;
    localparam logic [1:0] c_ADDR_INT_DUTY   = 2'd3;

    // Power-on values for both shadow and active copies
    localparam logic [7:0] c_RST_GEN_INP    = 8'd0;
    localparam logic [7:0] c_RST_PRED_SHIFT = 8'd30;
    localparam logic [6:0] c_RST_OCD_PW     = 7'd87;
    localparam logic [7:0] c_RST_INT_DUTY   = 8'd0;

    // One full parameter set, used for both the shadow and active banks
    typedef struct packed {
        logic [7:0] gen_inp;
        logic [7:0] pred_shift;
        logic [6:0] ocd_pw;
        logic [7:0] int_duty;
    } conf_regs_t;

    localparam conf_regs_t c_REGS_RST = '{
        gen_inp:    c_RST_GEN_INP,
        pred_shift: c_RST_PRED_SHIFT,
        ocd_pw:     c_RST_OCD_PW,
        int_duty:   c_RST_INT_DUTY
    };

endpackage
`default_nettype wire

// File: rtl/gap_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : gap_cnt                                                 |
// | Purpose  : Counts consecutive burst-free cycles, saturating at     |
// |            GAP_MIN; gap_ok flags a safe window for a commit.       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module gap_cnt #(
    parameter int GAP_MIN = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic burst_act,
    output logic gap_ok
);

    localparam int             c_GW      = $clog2(GAP_MIN + 1);
    localparam logic [c_GW-1:0] c_GAP_MAX = c_GW'(GAP_MIN);

    logic [c_GW-1:0] cnt_q;
    logic [c_GW-1:0] cnt_d;

    // Next count: any burst restarts the gap, otherwise count up to the cap
    always_comb begin
        cnt_d = cnt_q;
        if (burst_act) begin
            cnt_d = '0;
        end else if (cnt_q != c_GAP_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Gap counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Safe only if the gap is long enough and no burst starts this cycle
    assign gap_ok = (cnt_q == c_GAP_MAX) && !burst_act;

endmodule
`default_nettype wire

// File: rtl/conf_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : conf_sched                                              |
// | Purpose  : Double-buffered datapath parameters. Writes land in a   |
// |            shadow bank; a commit request copies the shadow into    |
// |            the active bank only inside a long enough burst gap.    |
// |            Optional ARMED timeout: define CONF_SCHED_TMO_EN.       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module conf_sched
    import conf_pkg::*;
#(
    parameter int GAP_MIN   = 64,
    parameter int TMO_CYC   = 65535,
    parameter int SHIFT_MAX = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       commit_req,
    input  logic       burst_act,
    output logic [7:0] gen_inp,
    output logic [7:0] pred_shift,
    output logic [6:0] ocd_pw,
    output logic [7:0] int_duty,
    output logic       busy,
    output logic       commit_done,
    output logic       tmo_err
);

    localparam logic [7:0] c_SHIFT_MAX = 8'(SHIFT_MAX);

    state_t     state_q, state_d;
    conf_regs_t shadow_q, shadow_d;
    conf_regs_t active_q, active_d;
    logic       done_q;
    logic       gap_ok;
    logic       load;

    gap_cnt #(
        .GAP_MIN (GAP_MIN)
    ) u_gap_cnt (
        .clk       (clk),
        .rst       (rst),
        .burst_act (burst_act),
        .gap_ok    (gap_ok)
    );

`ifdef CONF_SCHED_TMO_EN
    localparam int             c_TW       = $clog2(TMO_CYC + 1);
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(TMO_CYC - 1);

    logic [c_TW-1:0] tmo_cnt_q;
    logic            tmo_err_q;
    logic            tmo_hit;

    // Cycles spent in ARMED; restarts from zero on every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == ST_ARMED) ? tmo_cnt_q + 1'b1 : '0;
            if (tmo_hit) begin
                tmo_err_q <= 1'b1;
            end
        end
    end

    assign tmo_hit = (state_q == ST_ARMED) && !gap_ok && (tmo_cnt_q == c_TMO_LAST);
    assign tmo_err = tmo_err_q;
`else
    assign tmo_err = 1'b0;
`endif

    // Next-state logic; a commit window wins over a same-cycle timeout
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit_req) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (gap_ok) begin
                    state_d = ST_COMMIT;
                end
`ifdef CONF_SCHED_TMO_EN
                else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                load    = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow update; pred_shift is clamped, ocd_pw keeps the low seven bits
    always_comb begin
        shadow_d = shadow_q;
        if (wr_valid) begin
            case (wr_addr)
                c_ADDR_GEN_INP:    shadow_d.gen_inp    = wr_data;
                c_ADDR_PRED_SHIFT: shadow_d.pred_shift = (wr_data > c_SHIFT_MAX) ? c_SHIFT_MAX : wr_data;
                c_ADDR_OCD_PW:     shadow_d.ocd_pw     = wr_data[6:0];
                c_ADDR_INT_DUTY:   shadow_d.int_duty   = wr_data;
                default:           shadow_d            = shadow_q;
            endcase
        end
    end

    // Active bank takes the post-write shadow so a COMMIT-cycle write is included
    always_comb begin
        active_d = active_q;
        if (load) begin
            active_d = shadow_d;
        end
    end

    // State, banks and the commit_done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shadow_q <= c_REGS_RST;
            active_q <= c_REGS_RST;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= load;
        end
    end

    assign gen_inp     = active_q.gen_inp;
    assign pred_shift  = active_q.pred_shift;
    assign ocd_pw      = active_q.ocd_pw;
    assign int_duty    = active_q.int_duty;
    assign busy        = (state_q != ST_IDLE);
    assign commit_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conf_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_conf_sched                                           |
// | Purpose  : Directed self-checking bench for conf_sched.            |
// |            Timeout scenario active when CONF_SCHED_TMO_EN defined. |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module tb_conf_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit_req;
    logic       burst_act;
    logic [7:0] gen_inp;
    logic [7:0] pred_shift;
    logic [6:0] ocd_pw;
    logic [7:0] int_duty;
    logic       busy;
    logic       commit_done;
    logic       tmo_err;

    int n_checks = 0;
    int n_errors = 0;
    logic seen_done;

    conf_sched #(
        .GAP_MIN   (64),
        .TMO_CYC   (1000),
        .SHIFT_MAX (200)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (wr_valid),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .commit_req  (commit_req),
        .burst_act   (burst_act),
        .gen_inp     (gen_inp),
        .pred_shift  (pred_shift),
        .ocd_pw      (ocd_pw),
        .int_duty    (int_duty),
        .busy        (busy),
        .commit_done (commit_done),
        .tmo_err     (tmo_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] g, input logic [7:0] p,
                              input logic [6:0] o, input logic [7:0] d);
        check({tag, "_gen"},  {24'd0, gen_inp},    {24'd0, g});
        check({tag, "_pred"}, {24'd0, pred_shift}, {24'd0, p});
        check({tag, "_ocd"},  {25'd0, ocd_pw},     {25'd0, o});
        check({tag, "_duty"}, {24'd0, int_duty},   {24'd0, d});
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
        commit_req = 1'b0; burst_act = 1'b0;
        tick(2);
        rst = 1'b0;

        // Reset state
        check_outs("rst", 8'd0, 8'd30, 7'd87, 8'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, commit_done}, 32'd0);
        check("rst_tmo",  {31'd0, tmo_err}, 32'd0);

        // Basic commit with gap already satisfied: three-edge latency
        tick(70);
        write_reg(2'd1, 8'h50);
        check("shadow_only", {24'd0, pred_shift}, 32'd30);
        pulse_commit();
        check("e1_busy", {31'd0, busy}, 32'd1);
        check("e1_pred", {24'd0, pred_shift}, 32'd30);
        tick();
        check("e2_pred", {24'd0, pred_shift}, 32'd30);
        check("e2_done", {31'd0, commit_done}, 32'd0);
        tick();
        check("e3_pred", {24'd0, pred_shift}, 32'h50);
        check("e3_done", {31'd0, commit_done}, 32'd1);
        check("e3_busy", {31'd0, busy}, 32'd0);
        tick();
        check("done_pulse", {31'd0, commit_done}, 32'd0);

        // Burst hold-off: burst high at request, falls 100 cycles later
        burst_act = 1'b1;
        write_reg(2'd0, 8'h11);
        pulse_commit();
        tick(49);
        pulse_commit();
        tick(49);
        check("hold_gen",  {24'd0, gen_inp}, 32'd0);
        check("hold_busy", {31'd0, busy}, 32'd1);
        burst_act = 1'b0;
        tick(65);
        check("gap64_gen",  {24'd0, gen_inp}, 32'd0);
        check("gap64_done", {31'd0, commit_done}, 32'd0);
        tick();
        check("gap_gen",  {24'd0, gen_inp}, 32'h11);
        check("gap_done", {31'd0, commit_done}, 32'd1);
        tick();

        // Clamping of pred_shift and ocd_pw width
        write_reg(2'd1, 8'hFF);
        write_reg(2'd2, 8'hFF);
        pulse_commit();
        tick(2);
        check_outs("clamp", 8'h11, 8'd200, 7'h7F, 8'd0);

        // Write in the COMMIT cycle is taken, latest write wins
        write_reg(2'd3, 8'h10);
        pulse_commit();
        tick();
        wr_valid = 1'b1; wr_addr = 2'd3; wr_data = 8'h22;
        tick();
        wr_valid = 1'b0;
        check("cw_duty", {24'd0, int_duty}, 32'h22);
        check("cw_done", {31'd0, commit_done}, 32'd1);

        // Reset while ARMED, with a same-cycle write that must be dropped
        burst_act = 1'b1;
        write_reg(2'd0, 8'h77);
        pulse_commit();
        check("arm_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1; wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 8'h40;
        tick();
        rst = 1'b0; wr_valid = 1'b0;
        check_outs("midrst", 8'd0, 8'd30, 7'd87, 8'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        burst_act = 1'b0;
        seen_done = commit_done;
        for (int i = 0; i < 70; i++) begin
            tick();
            seen_done = seen_done | commit_done;
        end
        check("midrst_nodone", {31'd0, seen_done}, 32'd0);
        check("midrst_idle", {31'd0, busy}, 32'd0);
        pulse_commit();
        tick(2);
        check_outs("postrst", 8'd0, 8'd30, 7'd87, 8'd0);
        check("postrst_done", {31'd0, commit_done}, 32'd1);

        // ARMED with burst held high for 1000 cycles
        burst_act = 1'b1;
        write_reg(2'd0, 8'h5A);
        pulse_commit();
        tick(999);
        check("t999_busy", {31'd0, busy}, 32'd1);
        check("t999_tmo",  {31'd0, tmo_err}, 32'd0);
        tick();
        check("t1000_gen",  {24'd0, gen_inp}, 32'd0);
        check("t1000_done", {31'd0, commit_done}, 32'd0);
`ifdef CONF_SCHED_TMO_EN
        check("t1000_busy", {31'd0, busy}, 32'd0);
        check("t1000_tmo",  {31'd0, tmo_err}, 32'd1);
        burst_act = 1'b0;
        tick(70);
        pulse_commit();
        tick(2);
        check("tmo_shadow_gen", {24'd0, gen_inp}, 32'h5A);
        check("tmo_sticky", {31'd0, tmo_err}, 32'd1);
`else
        check("t1000_busy", {31'd0, busy}, 32'd1);
        check("t1000_tmo",  {31'd0, tmo_err}, 32'd0);
        burst_act = 1'b0;
        tick(66);
        check("late_gen",  {24'd0, gen_inp}, 32'h5A);
        check("late_done", {31'd0, commit_done}, 32'd1);
        check("late_tmo",  {31'd0, tmo_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
